// File: rtl/triangle_monitor_if.sv
// Carrier-monitor bundle: sample stream in, turnaround/period/lock status out.
// Latency: wires only; all timing lives in the monitor.
// Backpressure: none; en qualifies samples and the monitor never stalls the source.
interface triangle_monitor_if #(
    parameter int WIDTH    = 12,
    parameter int PERIOD_W = 16
);
    logic                en;
    logic                clr;
    logic [WIDTH-1:0]    sample;
    logic                dir;
    logic [WIDTH-1:0]    peak;
    logic [WIDTH-1:0]    valley;
    logic                peak_stb;
    logic                valley_stb;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                locked;
    logic                slope_err;
    logic [7:0]          err_cnt;

    // Carrier source / test side
    modport master (
        output en, clr, sample,
        input  dir, peak, valley, peak_stb, valley_stb,
        input  period, period_valid, locked, slope_err, err_cnt
    );

    // Monitor side
    modport slave (
        input  en, clr, sample,
        output dir, peak, valley, peak_stb, valley_stb,
        output period, period_valid, locked, slope_err, err_cnt
    );
endinterface

// File: rtl/triangle_monitor.sv
// Checks a triangular carrier: tracks slope, reports peak/valley, period, lock and slope errors.
// Latency: all outputs registered; an extremum is reported one clk after the sample that follows it.
// Backpressure: none; every clk with en=1 consumes a sample, en=0 freezes all state.
module triangle_monitor #(
    parameter int WIDTH    = 12,
    parameter int STEP     = 2,
    parameter int PERIOD_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    triangle_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQ     = 2'd1,
        S_RISING  = 2'd2,
        S_FALLING = 2'd3
    } state_t;

    // Legal deltas modulo 2^WIDTH; a falling step is the two's-complement of STEP.
    localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] STEP_DN = WIDTH'((1 << WIDTH) - STEP);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                seen_valley_q, seen_valley_d;
    logic                dir_q, dir_d;
    logic [WIDTH-1:0]    peak_q, peak_d;
    logic [WIDTH-1:0]    valley_q, valley_d;
    logic                peak_stb_q, peak_stb_d;
    logic                valley_stb_q, valley_stb_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_valid_q, period_valid_d;
    logic                locked_q, locked_d;
    logic                slope_err_q, slope_err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]    delta;
    logic                up, down, viol;

    // Wrap-around through zero is legal, so the difference is taken modulo 2^WIDTH.
    assign delta = mon.sample - prev_q;
    assign up    = (delta == STEP_UP);
    assign down  = (delta == STEP_DN);
    assign viol  = !(up || down);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: slope direction tracking, any illegal delta falls back to ACQ
    always_comb begin
        state_d = state_q;
        if (mon.en) begin
            case (state_q)
                S_IDLE:    state_d = S_ACQ;
                S_ACQ:     state_d = up ? S_RISING  : (down ? S_FALLING : S_ACQ);
                S_RISING:  state_d = up ? S_RISING  : (down ? S_FALLING : S_ACQ);
                S_FALLING: state_d = down ? S_FALLING : (up ? S_RISING : S_ACQ);
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Outputs and datapath next values; the error path overrides the valley path on cnt/lock
    always_comb begin
        prev_d         = prev_q;
        cnt_d          = cnt_q;
        seen_valley_d  = seen_valley_q;
        dir_d          = dir_q;
        peak_d         = peak_q;
        valley_d       = valley_q;
        period_d       = period_q;
        locked_d       = locked_q;
        slope_err_d    = slope_err_q;
        err_cnt_d      = err_cnt_q;
        peak_stb_d     = 1'b0;
        valley_stb_d   = 1'b0;
        period_valid_d = 1'b0;

        if (mon.en) begin
            prev_d = mon.sample;
            cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + PERIOD_W'(1);
            dir_d  = (state_d == S_RISING);

            if (state_q == S_RISING && down) begin
                peak_d     = prev_q;
                peak_stb_d = 1'b1;
            end

            if (state_q == S_FALLING && up) begin
                valley_d     = prev_q;
                valley_stb_d = 1'b1;
                // A period needs two valleys since the last error/reset.
                if (seen_valley_q) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    locked_d       = 1'b1;
                end
                cnt_d         = PERIOD_W'(1);
                seen_valley_d = 1'b1;
            end

            if (state_q != S_IDLE && viol) begin
                slope_err_d   = 1'b1;
                err_cnt_d     = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                locked_d      = 1'b0;
                seen_valley_d = 1'b0;
                cnt_d         = '0;
            end
        end

        // Clear wins over a same-cycle violation; FSM and lock are unaffected.
        if (mon.clr) begin
            slope_err_d = 1'b0;
            err_cnt_d   = 8'd0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q         <= '0;
            cnt_q          <= '0;
            seen_valley_q  <= 1'b0;
            dir_q          <= 1'b0;
            peak_q         <= '0;
            valley_q       <= '0;
            peak_stb_q     <= 1'b0;
            valley_stb_q   <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            slope_err_q    <= 1'b0;
            err_cnt_q      <= 8'd0;
        end else begin
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            seen_valley_q  <= seen_valley_d;
            dir_q          <= dir_d;
            peak_q         <= peak_d;
            valley_q       <= valley_d;
            peak_stb_q     <= peak_stb_d;
            valley_stb_q   <= valley_stb_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            slope_err_q    <= slope_err_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign mon.dir          = dir_q;
    assign mon.peak         = peak_q;
    assign mon.valley       = valley_q;
    assign mon.peak_stb     = peak_stb_q;
    assign mon.valley_stb   = valley_stb_q;
    assign mon.period       = period_q;
    assign mon.period_valid = period_valid_q;
    assign mon.locked       = locked_q;
    assign mon.slope_err    = slope_err_q;
    assign mon.err_cnt      = err_cnt_q;

endmodule
